evt_spike_collector: RTL and testbench

Downstream stage of the neuron datapath. Captures per-update spike outputs, tags each with neuron id and timestep, and buffers them in a FIFO. Inserts an end-of-timestep marker after the last spike of each step. Drains to the outbound event stream over a valid/ready handshake.

---
 rtl/evt_spike_collector_if.sv | 12 +
 rtl/evt_spike_collector.sv | 105 ++++++++++
 tb/tb_evt_spike_collector.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/evt_spike_collector_if.sv
// Outbound event stream of the spike collector: valid/ready handshake carrying
// {is_marker, time, neuron_id} words.
interface evt_spike_collector_if #(
  parameter int DATA_W = 21
);
  logic              evt_valid_o;
  logic              evt_ready_i;
  logic [DATA_W-1:0] evt_data_o;

  modport master (output evt_valid_o, output evt_data_o, input evt_ready_i);
  modport slave  (input evt_valid_o, input evt_data_o, output evt_ready_i);
endinterface

// File: rtl/evt_spike_collector.sv
// Collects spikes from the neuron datapath, tags them with id/timestep and
// buffers them with end-of-timestep markers for the outbound event stream.
module evt_spike_collector #(
  parameter int FIFO_DEPTH  = 8,
  parameter int NEURON_ID_W = 12,
  parameter int TIME_W      = 8
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                enable_i,
  input  logic                                spike_valid_i,
  input  logic                                spike_i,
  input  logic [NEURON_ID_W-1:0]              neuron_id_i,
  input  logic [TIME_W-1:0]                   time_i,
  input  logic                                tstep_done_i,
  input  logic                                clear_stat_i,
  evt_spike_collector_if.master               evt,
  output logic [$clog2(FIFO_DEPTH):0]         fifo_level_o,
  output logic [15:0]                         drop_cnt_o,
  output logic                                marker_err_o,
  output logic                                busy_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = 1 + TIME_W + NEURON_ID_W;

  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     spike_ptr;
  logic [LW-1:0]     level;
  logic [LW-1:0]     free_slots;
  logic              marker_pending;
  logic [TIME_W-1:0] marker_time;
  logic [15:0]       drop_cnt;
  logic              marker_err;

  logic spike_req;
  logic marker_write;
  logic spike_accept;
  logic spike_drop;
  logic pop;
  logic marker_conflict;

  // Free space is taken at the start of the cycle; a same-cycle pop does not help.
  assign free_slots   = LW'(FIFO_DEPTH) - level;
  assign marker_write = marker_pending && (free_slots != '0);
  assign spike_req    = enable_i & spike_valid_i & spike_i;
  // A spike must leave one slot behind it so the next marker always fits.
  assign spike_accept = spike_req && (free_slots >= (LW'(2) + LW'(marker_write)));
  assign spike_drop   = spike_req & ~spike_accept;
  assign pop          = (level != '0) & evt.evt_ready_i;
  assign marker_conflict = tstep_done_i & marker_pending & ~marker_write;
  assign spike_ptr    = marker_write ? wr_ptr + AW'(1) : wr_ptr;

  always_ff @(posedge clk_i) begin
    if (marker_write) mem[wr_ptr] <= {1'b1, marker_time, {NEURON_ID_W{1'b0}}};
    if (spike_accept) mem[spike_ptr] <= {1'b0, time_i, neuron_id_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(marker_write) + AW'(spike_accept);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      level  <= level - LW'(pop) + LW'(marker_write) + LW'(spike_accept);
    end
  end

  // A step ending while the previous marker is still being written re-arms with the new time.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      marker_pending <= 1'b0;
      marker_time    <= '0;
    end else if (tstep_done_i && !marker_conflict) begin
      marker_pending <= 1'b1;
      marker_time    <= time_i;
    end else if (marker_write) begin
      marker_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_cnt   <= '0;
      marker_err <= 1'b0;
    end else begin
      if (clear_stat_i) drop_cnt <= {15'd0, spike_drop};
      else if (spike_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;

      if (clear_stat_i) marker_err <= marker_conflict;
      else if (marker_conflict) marker_err <= 1'b1;
    end
  end

  assign evt.evt_valid_o = (level != '0);
  assign evt.evt_data_o  = (level != '0) ? mem[rd_ptr] : '0;
  assign fifo_level_o    = level;
  assign drop_cnt_o      = drop_cnt;
  assign marker_err_o    = marker_err;
  assign busy_o          = (level != '0) | marker_pending;
endmodule

// File: tb/tb_evt_spike_collector.sv
// Self-checking bench for evt_spike_collector: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_evt_spike_collector;
  localparam int DEPTH = 8;
  localparam int IDW   = 12;
  localparam int TW    = 8;
  localparam int EW    = 1 + TW + IDW;
  localparam int LW    = 4;
  localparam int VW    = 1 + EW + LW + 16 + 1 + 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           enable = 1'b0;
  logic           spike_valid = 1'b0;
  logic           spike = 1'b0;
  logic [IDW-1:0] neuron_id = '0;
  logic [TW-1:0]  time_v = '0;
  logic           tstep_done = 1'b0;
  logic           clear_stat = 1'b0;
  logic [LW-1:0]  fifo_level;
  logic [15:0]    drop_cnt;
  logic           marker_err;
  logic           busy;

  evt_spike_collector_if #(.DATA_W(EW)) evt_if ();

  evt_spike_collector #(
    .FIFO_DEPTH(DEPTH), .NEURON_ID_W(IDW), .TIME_W(TW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .spike_valid_i(spike_valid),
    .spike_i(spike), .neuron_id_i(neuron_id), .time_i(time_v),
    .tstep_done_i(tstep_done), .clear_stat_i(clear_stat), .evt(evt_if),
    .fifo_level_o(fifo_level), .drop_cnt_o(drop_cnt), .marker_err_o(marker_err),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Reference model: the FIFO as a queue of whole events
  logic [EW-1:0] mq[$];
  bit            m_pending;
  logic [TW-1:0] m_time;
  logic [15:0]   m_drop;
  bit            m_err;
  bit            popped_now;
  logic [EW-1:0] last_pop;
  int            checks = 0;
  int            errors = 0;

  task automatic model_reset();
    mq.delete();
    m_pending = 0;
    m_time = '0;
    m_drop = '0;
    m_err = 0;
    popped_now = 0;
  endtask

  task automatic model_update();
    int free_n;
    bit mw, req, acc, pop, err_now;
    free_n  = DEPTH - mq.size();
    mw      = m_pending && (free_n >= 1);
    req     = (enable && spike_valid && spike);
    acc     = req && ((free_n - (mw ? 1 : 0)) >= 2);
    pop     = (mq.size() != 0) && (evt_if.evt_ready_i == 1'b1);
    err_now = (tstep_done == 1'b1) && m_pending && !mw;
    popped_now = pop;
    if (pop) last_pop = mq.pop_front();
    if (mw) mq.push_back({1'b1, m_time, {IDW{1'b0}}});
    if (acc) mq.push_back({1'b0, time_v, neuron_id});
    if (tstep_done && !err_now) begin
      m_pending = 1;
      m_time = time_v;
    end else if (mw) begin
      m_pending = 0;
    end
    if (clear_stat) m_drop = (req && !acc) ? 16'd1 : 16'd0;
    else if (req && !acc && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
    if (clear_stat) m_err = err_now;
    else if (err_now) m_err = 1;
  endtask

  function automatic logic [VW-1:0] model_view();
    logic [EW-1:0] head;
    head = (mq.size() != 0) ? mq[0] : '0;
    return {mq.size() != 0, head, LW'(mq.size()), m_drop, m_err, (mq.size() != 0) || m_pending};
  endfunction

  function automatic logic [VW-1:0] dut_view();
    return {evt_if.evt_valid_o, evt_if.evt_data_o, fifo_level, drop_cnt, marker_err, busy};
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_spike(input bit on, input int id, input int t);
    spike_valid = on;
    spike = on;
    neuron_id = IDW'(id);
    time_v = TW'(t);
  endtask

  task automatic test_reset();
    model_reset();
    evt_if.evt_ready_i = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_view() !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", dut_view());
    end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [EW-1:0] e;
    evt_if.evt_ready_i = 1'b1;
    enable = 1'b1;
    set_spike(1, 3, 5);
    step();
    e = {1'b0, 8'd5, 12'd3};
    checks++;
    if ({evt_if.evt_valid_o, evt_if.evt_data_o} !== {1'b1, e}) begin
      errors++;
      $display("[TB] FAIL basic_first: got %h expected %h", {evt_if.evt_valid_o, evt_if.evt_data_o}, {1'b1, e});
    end
    set_spike(1, 7, 5);
    tstep_done = 1'b1;
    step();
    tstep_done = 1'b0;
    set_spike(0, 0, 5);
    e = {1'b0, 8'd5, 12'd7};
    checks++;
    if ({evt_if.evt_valid_o, evt_if.evt_data_o, busy} !== {1'b1, e, 1'b1}) begin
      errors++;
      $display("[TB] FAIL basic_second: got %h expected %h", {evt_if.evt_valid_o, evt_if.evt_data_o, busy}, {1'b1, e, 1'b1});
    end
    step();
    e = {1'b1, 8'd5, 12'd0};
    checks++;
    if ({evt_if.evt_valid_o, evt_if.evt_data_o} !== {1'b1, e}) begin
      errors++;
      $display("[TB] FAIL basic_marker: got %h expected %h", {evt_if.evt_valid_o, evt_if.evt_data_o}, {1'b1, e});
    end
    step();
    checks++;
    if ({evt_if.evt_valid_o, busy} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL basic_idle: got valid=%b busy=%b expected 0 0", evt_if.evt_valid_o, busy);
    end
  endtask

  task automatic test_fill();
    clear_stat = 1'b1;
    step();
    clear_stat = 1'b0;
    evt_if.evt_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_spike(1, 100 + i, 6);
      step();
    end
    set_spike(0, 0, 6);
    checks++;
    if ({fifo_level, drop_cnt} !== {4'd7, 16'd3}) begin
      errors++;
      $display("[TB] FAIL fill_level_drop: got level=%0d drop=%0d expected 7 3", fifo_level, drop_cnt);
    end
    time_v = 8'd9;
    tstep_done = 1'b1;
    step();
    tstep_done = 1'b0;
    step();
    checks++;
    if ({fifo_level, busy} !== {4'd8, 1'b1}) begin
      errors++;
      $display("[TB] FAIL fill_marker: got level=%0d busy=%b expected 8 1", fifo_level, busy);
    end
  endtask

  task automatic test_full_drain();
    logic [EW-1:0] e;
    bit found;
    for (int i = 0; i < 3; i++) begin
      set_spike(1, 200 + i, 6);
      step();
    end
    checks++;
    if ({fifo_level, drop_cnt} !== {4'd8, 16'd6}) begin
      errors++;
      $display("[TB] FAIL full_drops: got level=%0d drop=%0d expected 8 6", fifo_level, drop_cnt);
    end
    evt_if.evt_ready_i = 1'b1;
    set_spike(1, 210, 6);
    step();
    e = {1'b0, 8'd6, 12'd101};
    checks++;
    if ({fifo_level, drop_cnt, evt_if.evt_data_o} !== {4'd7, 16'd7, e}) begin
      errors++;
      $display("[TB] FAIL first_pop_drop: got level=%0d drop=%0d data=%h expected 7 7 %h", fifo_level, drop_cnt, evt_if.evt_data_o, e);
    end
    set_spike(1, 211, 6);
    step();
    checks++;
    if ({fifo_level, drop_cnt} !== {4'd6, 16'd8}) begin
      errors++;
      $display("[TB] FAIL reserve_slot_drop: got level=%0d drop=%0d expected 6 8", fifo_level, drop_cnt);
    end
    set_spike(1, 212, 6);
    step();
    set_spike(0, 0, 6);
    checks++;
    if ({fifo_level, drop_cnt} !== {4'd6, 16'd8}) begin
      errors++;
      $display("[TB] FAIL accept_after_space: got level=%0d drop=%0d expected 6 8", fifo_level, drop_cnt);
    end
    found = 0;
    for (int c = 0; c < 40 && busy; c++) begin
      step();
      if (popped_now && last_pop == {1'b0, 8'd6, 12'd212}) found = 1;
      checks++;
      if (dut_view() !== model_view()) begin
        errors++;
        $display("[TB] FAIL drain_cycle %0d: got %h expected %h", c, dut_view(), model_view());
      end
    end
    checks++;
    if ({busy, found} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL drain_end: got busy=%b found212=%b expected 0 1", busy, found);
    end
  endtask

  task automatic test_marker_err();
    int markers;
    logic [TW-1:0] last_mt;
    clear_stat = 1'b1;
    step();
    clear_stat = 1'b0;
    evt_if.evt_ready_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      set_spike(1, 300 + i, 11);
      step();
    end
    set_spike(0, 0, 11);
    tstep_done = 1'b1;
    step();
    tstep_done = 1'b0;
    step();
    time_v = 8'd12;
    tstep_done = 1'b1;
    step();
    checks++;
    if ({fifo_level, marker_err} !== {4'd8, 1'b0}) begin
      errors++;
      $display("[TB] FAIL first_pulse: got level=%0d err=%b expected 8 0", fifo_level, marker_err);
    end
    time_v = 8'd13;
    step();
    tstep_done = 1'b0;
    checks++;
    if (marker_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL marker_err_set: got %b expected 1", marker_err);
    end
    clear_stat = 1'b1;
    set_spike(1, 400, 13);
    step();
    clear_stat = 1'b0;
    set_spike(0, 0, 13);
    checks++;
    if ({drop_cnt, marker_err} !== {16'd1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL clear_with_drop: got drop=%0d err=%b expected 1 0", drop_cnt, marker_err);
    end
    evt_if.evt_ready_i = 1'b1;
    markers = 0;
    last_mt = '0;
    for (int c = 0; c < 40 && busy; c++) begin
      step();
      if (popped_now && last_pop[EW-1]) begin
        markers++;
        last_mt = last_pop[EW-2 -: TW];
      end
      checks++;
      if (dut_view() !== model_view()) begin
        errors++;
        $display("[TB] FAIL err_drain_cycle %0d: got %h expected %h", c, dut_view(), model_view());
      end
    end
    checks++;
    if (markers != 2 || last_mt !== 8'd12 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL marker_count: got markers=%0d time=%0d busy=%b expected 2 12 0", markers, last_mt, busy);
    end
  endtask

  task automatic test_back_to_back();
    int prev_id;
    prev_id = -1;
    for (int c = 0; c < 60; c++) begin
      if (c <= 20) set_spike(1, c, 20);
      else set_spike(0, 0, 20);
      evt_if.evt_ready_i = (c % 2 == 0);
      step();
      checks++;
      if (dut_view() !== model_view()) begin
        errors++;
        $display("[TB] FAIL b2b_cycle %0d: got %h expected %h", c, dut_view(), model_view());
      end
      if (popped_now) begin
        checks++;
        if (int'(last_pop[IDW-1:0]) <= prev_id || last_pop[EW-1]) begin
          errors++;
          $display("[TB] FAIL b2b_order: got id %0d after %0d expected increasing spike ids", last_pop[IDW-1:0], prev_id);
        end
        prev_id = int'(last_pop[IDW-1:0]);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_drain: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_random();
    logic [TW-1:0] t;
    t = 8'd30;
    for (int c = 0; c < 400; c++) begin
      enable      = ($urandom_range(0, 9) != 0);
      spike_valid = $urandom_range(0, 1);
      spike       = ($urandom_range(0, 3) != 0);
      neuron_id   = IDW'($urandom);
      tstep_done  = ($urandom_range(0, 11) == 0);
      clear_stat  = ($urandom_range(0, 39) == 0);
      evt_if.evt_ready_i = ($urandom_range(0, 4) < 3);
      time_v = t;
      step();
      if (tstep_done) t = t + 8'd1;
      checks++;
      if (dut_view() !== model_view()) begin
        errors++;
        $display("[TB] FAIL rand_cycle %0d: got %h expected %h", c, dut_view(), model_view());
      end
    end
    set_spike(0, 0, t);
    tstep_done = 1'b0;
    clear_stat = 1'b0;
    enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    evt_if.evt_ready_i = 1'b1;
    for (int c = 0; c < 20 && busy; c++) step();
    evt_if.evt_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_spike(1, 500 + i, 40);
      step();
    end
    set_spike(0, 0, 40);
    tstep_done = 1'b1;
    step();
    tstep_done = 1'b0;
    checks++;
    if ({fifo_level, busy} !== {4'd5, 1'b1}) begin
      errors++;
      $display("[TB] FAIL pre_reset: got level=%0d busy=%b expected 5 1", fifo_level, busy);
    end
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_view() !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset_outputs: got %h expected 0", dut_view());
    end
    #2 rst_n = 1'b1;
    evt_if.evt_ready_i = 1'b1;
    for (int c = 0; c < 3; c++) step();
    checks++;
    if ({evt_if.evt_valid_o, busy, fifo_level} !== '0) begin
      errors++;
      $display("[TB] FAIL no_stale: got valid=%b busy=%b level=%0d expected 0 0 0", evt_if.evt_valid_o, busy, fifo_level);
    end
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_spike(1, 600 + i, 41);
      step();
    end
    set_spike(0, 0, 41);
    checks++;
    if ({drop_cnt, fifo_level, evt_if.evt_valid_o} !== {16'd0, 4'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL disabled_spikes: got drop=%0d level=%0d valid=%b expected 0 0 0", drop_cnt, fifo_level, evt_if.evt_valid_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_full_drain();
    test_marker_err();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
